// File: rtl/multi_wave_gen_pkg.sv
// Shared types and constants for the multi-channel wave generator.
package mwg_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_PULSE = 2'd1,
      MODE_SAW   = 2'd2,
      MODE_TRI   = 2'd3
   } mode_e;

   localparam logic [1:0] CFG_STEP = 2'd0;
   localparam logic [1:0] CFG_DUTY = 2'd1;
   localparam logic [1:0] CFG_MODE = 2'd2;
   localparam logic [1:0] CFG_VOL  = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } state_e;

   // Channel-select width; a single channel still gets a one-bit select.
   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_wave_gen_wave_shape.sv
// Combinational waveform shaper and volume scaler, shared by all channels.
module wave_shape
   import mwg_pkg::*;
#(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned OUT_W = 8
) (
   input  logic [1:0]       i_mode,
   input  logic [ACC_W-1:0] i_phase,
   input  logic [15:0]      i_duty,
   input  logic [7:0]       i_volume,
   output logic [OUT_W-1:0] o_scaled
);

   logic [15:0]      w_p;
   logic [OUT_W-1:0] w_tri_t;
   logic [OUT_W-1:0] w_wave;
   logic [8:0]       w_vol_p1;
   logic [OUT_W+8:0] w_prod;
   logic             w_unused;

   assign w_p     = i_phase[ACC_W-1 -: 16];
   assign w_tri_t = i_phase[ACC_W-2 -: OUT_W];

   always_comb begin
      w_wave = '0;
      case (i_mode)
         MODE_OFF:   w_wave = '0;
         MODE_PULSE: w_wave = (w_p < i_duty) ? '1 : '0;
         MODE_SAW:   w_wave = i_phase[ACC_W-1 -: OUT_W];
         MODE_TRI:   w_wave = i_phase[ACC_W-1] ? ~w_tri_t : w_tri_t;
         default:    w_wave = '0;
      endcase
   end

   // (wave * (volume + 1)) >> 8 never exceeds the all-ones wave value.
   assign w_vol_p1 = {1'b0, i_volume} + 9'd1;
   assign w_prod   = {9'd0, w_wave} * {{OUT_W{1'b0}}, w_vol_p1};
   assign o_scaled = w_prod[OUT_W+7 -: OUT_W];

   assign w_unused = ^{i_phase, w_prod[OUT_W+8]};

endmodule

// File: rtl/multi_wave_gen.sv
// NUM_CH-channel phase-accumulator wave generator, mixed into one sample per period.
// Define MIX_SATURATE_EN for a saturating sum instead of the channel average.
module multi_wave_gen
   import mwg_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned ACC_W      = 32,
   parameter int unsigned OUT_W      = 8,
   parameter int unsigned SAMPLE_DIV = 2048
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_cfg_valid,
   output logic                      o_cfg_ready,
   input  logic [ch_w(NUM_CH)-1:0]   i_cfg_ch,
   input  logic [1:0]                i_cfg_addr,
   input  logic [ACC_W-1:0]          i_cfg_data,
   output logic [OUT_W-1:0]          o_amplitude,
   output logic                      o_sample_strobe
);

   localparam int unsigned CH_W   = ch_w(NUM_CH);
   localparam int unsigned LOG_CH = $clog2(NUM_CH);
   localparam int unsigned SUM_W  = OUT_W + LOG_CH;
   localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   if (SAMPLE_DIV <= NUM_CH + 2) begin : g_bad_div
      $error("SAMPLE_DIV must exceed NUM_CH+2");
   end
   if ((NUM_CH < 1) || (NUM_CH > 16) || ((NUM_CH & (NUM_CH - 1)) != 0)) begin : g_bad_ch
      $error("NUM_CH must be a power of 2 in 1..16");
   end
   if (ACC_W < 16) begin : g_bad_acc
      $error("ACC_W must be at least 16");
   end

   state_e           r_state, w_state_next;
   logic [DIV_W-1:0] r_div;
   logic             r_tick;
   logic [CH_W-1:0]  r_idx;
   logic [SUM_W-1:0] r_sum;
   logic [OUT_W-1:0] r_amp;

   logic [ACC_W-1:0] r_step  [NUM_CH];
   logic [ACC_W-1:0] r_phase [NUM_CH];
   logic [15:0]      r_duty  [NUM_CH];
   logic [1:0]       r_mode  [NUM_CH];
   logic [7:0]       r_vol   [NUM_CH];

   logic [ACC_W-1:0] w_cur_phase;
   logic [15:0]      w_cur_duty;
   logic [1:0]       w_cur_mode;
   logic [7:0]       w_cur_vol;
   logic [OUT_W-1:0] w_scaled;
   logic [SUM_W-1:0] w_sum_next;
   logic [OUT_W-1:0] w_mix;
   logic             w_last;
   logic             w_div_wrap;
   logic             w_cfg_fire;
   logic             w_unused;

   always_comb begin
      w_cur_phase = '0;
      w_cur_duty  = '0;
      w_cur_mode  = '0;
      w_cur_vol   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (r_idx == CH_W'(c)) begin
            w_cur_phase = r_phase[c];
            w_cur_duty  = r_duty[c];
            w_cur_mode  = r_mode[c];
            w_cur_vol   = r_vol[c];
         end
      end
   end

   wave_shape #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_wave_shape (
      .i_mode   (w_cur_mode),
      .i_phase  (w_cur_phase),
      .i_duty   (w_cur_duty),
      .i_volume (w_cur_vol),
      .o_scaled (w_scaled)
   );

   assign w_sum_next = r_sum + SUM_W'(w_scaled);
   assign w_last     = (r_idx == CH_W'(NUM_CH - 1));
   assign w_div_wrap = (r_div == DIV_W'(SAMPLE_DIV - 1));
   assign w_cfg_fire = i_cfg_valid & o_cfg_ready;

`ifdef MIX_SATURATE_EN
   assign w_mix = (w_sum_next > SUM_W'({OUT_W{1'b1}})) ? '1 : w_sum_next[OUT_W-1:0];
`else
   assign w_mix = w_sum_next[SUM_W-1 -: OUT_W];
`endif

   assign w_unused = ^w_sum_next;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (r_tick) w_state_next = ACCUM;
         ACCUM:   if (w_last) w_state_next = OUTPUT;
         OUTPUT:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_div   <= '0;
         r_tick  <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_amp   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_step[c]  <= '0;
            r_phase[c] <= '0;
            r_duty[c]  <= '0;
            r_mode[c]  <= '0;
            r_vol[c]   <= '0;
         end
      end else begin
         r_state <= w_state_next;
         r_div   <= w_div_wrap ? '0 : r_div + DIV_W'(1);
         // Registered so the tick lands in the cycle the divider reads 0 after wrapping.
         r_tick  <= w_div_wrap;
         if ((r_state == IDLE) && r_tick) begin
            r_idx <= '0;
            r_sum <= '0;
         end
         if (r_state == ACCUM) begin
            r_idx <= r_idx + CH_W'(1);
            r_sum <= w_sum_next;
            if (w_last) r_amp <= w_mix;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if ((r_state == ACCUM) && (r_idx == CH_W'(c)) && (r_mode[c] != MODE_OFF)) begin
               r_phase[c] <= r_phase[c] + r_step[c];
            end
            // Writes only land in IDLE, so they never race the phase update above.
            if (w_cfg_fire && (i_cfg_ch == CH_W'(c))) begin
               case (i_cfg_addr)
                  CFG_STEP: r_step[c] <= i_cfg_data;
                  CFG_DUTY: r_duty[c] <= i_cfg_data[15:0];
                  CFG_MODE: begin
                     r_mode[c]  <= i_cfg_data[1:0];
                     r_phase[c] <= '0;
                  end
                  CFG_VOL:  r_vol[c] <= i_cfg_data[7:0];
                  default:  ;
               endcase
            end
         end
      end
   end

   assign o_cfg_ready     = (r_state == IDLE);
   assign o_amplitude     = r_amp;
   assign o_sample_strobe = (r_state == OUTPUT);

endmodule

// File: tb/tb_multi_wave_gen.sv
// Self-checking bench for multi_wave_gen (NUM_CH=4, ACC_W=32, OUT_W=8, SAMPLE_DIV=16).
module tb_multi_wave_gen;

   localparam int NCH = 4;
   localparam int DIV = 16;
   localparam int LAT = DIV + NCH + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_ch = '0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic [7:0]  amplitude;
   logic        sample_strobe;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic [7:0] q_exp[$];

   multi_wave_gen #(
      .NUM_CH     (NCH),
      .ACC_W      (32),
      .OUT_W      (8),
      .SAMPLE_DIV (DIV)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_cfg_valid     (cfg_valid),
      .o_cfg_ready     (cfg_ready),
      .i_cfg_ch        (cfg_ch),
      .i_cfg_addr      (cfg_addr),
      .i_cfg_data      (cfg_data),
      .o_amplitude     (amplitude),
      .o_sample_strobe (sample_strobe)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   // Expected mixed output for a given raw sum of scaled channel values.
   function automatic logic [7:0] mix_exp(input int sum);
`ifdef MIX_SATURATE_EN
      return (sum > 255) ? 8'd255 : 8'(sum);
`else
      return 8'(sum >> 2);
`endif
   endfunction

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic cfg_write(input int ch, input logic [1:0] addr, input logic [31:0] data);
      bit acc = 1'b0;
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_addr  = addr;
      cfg_data  = data;
      for (int i = 0; i < 64 && !acc; i++) begin
         acc = cfg_ready;
         @(posedge clk);
         #1;
      end
      cfg_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         $display("FAIL cfg_write: cfg_ready never seen in 64 cycles, expected 1");
      end
   endtask

   task automatic wait_strobe(output logic [7:0] amp, output int at_cyc, output bit ok);
      ok     = 1'b0;
      amp    = '0;
      at_cyc = 0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (sample_strobe) begin
            ok     = 1'b1;
            amp    = amplitude;
            at_cyc = cyc;
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] amp, exp_v;
      int c0, at, at2;
      bit ok;
      do_reset(3);
      c0 = cyc;
      n_checks++;
      if (amplitude !== 8'd0) $display("FAIL reset_amp: got %0d, expected 0", amplitude);
      else n_pass++;
      n_checks++;
      if (sample_strobe !== 1'b0) $display("FAIL reset_strobe: got %b, expected 0", sample_strobe);
      else n_pass++;
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b, expected 1", cfg_ready);
      else n_pass++;
      q_exp.push_back(8'd0);
      wait_strobe(amp, at, ok);
      exp_v = q_exp.pop_front();
      n_checks++;
      if (!ok || (at - c0) != LAT)
         $display("FAIL reset_latency: strobe %0b after %0d cycles, expected %0d", ok, at - c0, LAT);
      else n_pass++;
      n_checks++;
      if (!ok || amp !== exp_v) $display("FAIL reset_first_amp: got %0d, expected %0d", amp, exp_v);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (sample_strobe !== 1'b0) $display("FAIL strobe_width: got %b one cycle later, expected 0", sample_strobe);
      else n_pass++;
      wait_strobe(amp, at2, ok);
      n_checks++;
      if (!ok || (at2 - at) != DIV) $display("FAIL strobe_period: got %0d, expected %0d", at2 - at, DIV);
      else n_pass++;
   endtask

   task automatic test_saw();
      logic [7:0] amp, exp_v;
      int at;
      bit ok;
      do_reset(2);
      cfg_write(0, 2'd0, 32'h1000_0000);
      cfg_write(0, 2'd3, 32'd255);
      cfg_write(0, 2'd2, 32'd2);
      for (int k = 0; k <= 16; k++) q_exp.push_back(mix_exp((16 * k) % 256));
      for (int k = 0; k <= 16; k++) begin
         wait_strobe(amp, at, ok);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (!ok || amp !== exp_v) $display("FAIL saw[%0d]: got %0d (strobe %0b), expected %0d", k, amp, ok, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_pulse();
      logic [7:0] amp, exp_v;
      int at;
      bit ok;
      do_reset(2);
      cfg_write(1, 2'd0, 32'h2000_0000);
      cfg_write(1, 2'd1, 32'h0000_8000);
      cfg_write(1, 2'd3, 32'd255);
      cfg_write(1, 2'd2, 32'd1);
      for (int k = 0; k < 16; k++) q_exp.push_back(((k % 8) < 4) ? mix_exp(255) : 8'd0);
      for (int k = 0; k < 16; k++) begin
         wait_strobe(amp, at, ok);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (!ok || amp !== exp_v) $display("FAIL pulse[%0d]: got %0d (strobe %0b), expected %0d", k, amp, ok, exp_v);
         else n_pass++;
      end
      cfg_write(1, 2'd1, 32'd0);
      for (int k = 0; k < 4; k++) q_exp.push_back(8'd0);
      for (int k = 0; k < 4; k++) begin
         wait_strobe(amp, at, ok);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (!ok || amp !== exp_v) $display("FAIL pulse_duty0[%0d]: got %0d, expected %0d", k, amp, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      logic [7:0] amp, exp_v;
      int at, prev_at, strobe_cyc, acc_cyc;
      bit ok, acc, seen;
      do_reset(2);
      cfg_write(0, 2'd0, 32'h1000_0000);
      cfg_write(0, 2'd3, 32'd255);
      cfg_write(0, 2'd2, 32'd2);
      q_exp.push_back(mix_exp(0));
      q_exp.push_back(mix_exp(16));
      q_exp.push_back(mix_exp(8));
      q_exp.push_back(mix_exp(12));
      wait_strobe(amp, prev_at, ok);
      exp_v = q_exp.pop_front();
      n_checks++;
      if (!ok || amp !== exp_v) $display("FAIL stall_s1: got %0d, expected %0d", amp, exp_v);
      else n_pass++;
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      // Now in the first ACCUM cycle: request a volume change.
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_addr  = 2'd3;
      cfg_data  = 32'd63;
      n_checks++;
      if (cfg_ready !== 1'b0) $display("FAIL stall_ready: got %b during ACCUM, expected 0", cfg_ready);
      else n_pass++;
      acc = 1'b0;
      seen = 1'b0;
      strobe_cyc = 0;
      acc_cyc = 0;
      amp = '0;
      for (int i = 0; i < 32 && !acc; i++) begin
         if (cfg_ready) begin
            acc = 1'b1;
            acc_cyc = cyc;
         end
         @(posedge clk);
         #1;
         if (sample_strobe && !seen) begin
            seen = 1'b1;
            strobe_cyc = cyc;
            amp = amplitude;
         end
      end
      cfg_valid = 1'b0;
      exp_v = q_exp.pop_front();
      n_checks++;
      if (!seen || amp !== exp_v) $display("FAIL stall_s2: got %0d (strobe %0b), expected %0d", amp, seen, exp_v);
      else n_pass++;
      n_checks++;
      if (!acc || acc_cyc <= strobe_cyc)
         $display("FAIL stall_accept: accepted %0b at %0d, strobe at %0d, expected accept after strobe", acc, acc_cyc, strobe_cyc);
      else n_pass++;
      n_checks++;
      if ((strobe_cyc - prev_at) != DIV) $display("FAIL stall_period2: got %0d, expected %0d", strobe_cyc - prev_at, DIV);
      else n_pass++;
      prev_at = strobe_cyc;
      for (int k = 0; k < 2; k++) begin
         wait_strobe(amp, at, ok);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (!ok || amp !== exp_v) $display("FAIL stall_s%0d: got %0d, expected %0d", k + 3, amp, exp_v);
         else n_pass++;
         n_checks++;
         if ((at - prev_at) != DIV) $display("FAIL stall_period%0d: got %0d, expected %0d", k + 3, at - prev_at, DIV);
         else n_pass++;
         prev_at = at;
      end
   endtask

   task automatic test_mix_and_reset_mid();
      logic [7:0] amp, exp_v;
      int at, c0;
      bit ok, stray;
      do_reset(2);
      for (int ch = 0; ch < 2; ch++) begin
         cfg_write(ch, 2'd0, 32'h1000_0000);
         cfg_write(ch, 2'd1, 32'h0000_FFFF);
         cfg_write(ch, 2'd3, 32'd199);
         cfg_write(ch, 2'd2, 32'd1);
      end
      for (int k = 0; k < 3; k++) q_exp.push_back(mix_exp(398));
      for (int k = 0; k < 3; k++) begin
         wait_strobe(amp, at, ok);
         exp_v = q_exp.pop_front();
         n_checks++;
         if (!ok || amp !== exp_v) $display("FAIL mix[%0d]: got %0d, expected %0d", k, amp, exp_v);
         else n_pass++;
      end
      repeat (13) begin
         @(posedge clk);
         #1;
      end
      // Second ACCUM cycle of this period: abort with reset.
      stray = sample_strobe;
      do_reset(1);
      c0 = cyc;
      stray = stray | sample_strobe;
      n_checks++;
      if (stray) $display("FAIL midrst_strobe: got strobe 1 in aborted period, expected 0");
      else n_pass++;
      n_checks++;
      if (amplitude !== 8'd0) $display("FAIL midrst_amp: got %0d, expected 0", amplitude);
      else n_pass++;
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL midrst_ready: got %b, expected 1", cfg_ready);
      else n_pass++;
      // Only volume and mode are rewritten; a surviving step would make the saw move.
      cfg_write(0, 2'd3, 32'd255);
      cfg_write(0, 2'd2, 32'd2);
      for (int k = 0; k < 3; k++) q_exp.push_back(mix_exp(0));
      for (int k = 0; k < 3; k++) begin
         wait_strobe(amp, at, ok);
         exp_v = q_exp.pop_front();
         if (k == 0) begin
            n_checks++;
            if (!ok || (at - c0) != LAT)
               $display("FAIL midrst_latency: got %0d cycles, expected %0d", at - c0, LAT);
            else n_pass++;
         end
         n_checks++;
         if (!ok || amp !== exp_v) $display("FAIL midrst_cleared[%0d]: got %0d, expected %0d", k, amp, exp_v);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_saw();
      test_pulse();
      test_stall();
      test_mix_and_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_wave_gen.md
Name: multi_wave_gen

Overview:
- Parametrised successor to the single-channel pulse generator.
- NUM_CH independent phase-accumulator channels. Each channel is selectable as off, pulse (variable duty), sawtooth or triangle, with per-channel volume.
- Channels are time-multiplexed through one shaping/scaling datapath and mixed into one OUT_W-bit amplitude per sample period.
- Output drives the existing audio PWM stage directly. Configured at runtime over a valid/ready write port.

Parameters:
- NUM_CH, 4, channel count; power of 2, 1..16.
- ACC_W, 32, phase accumulator width; >= 16.
- OUT_W, 8, amplitude width.
- SAMPLE_DIV, 2048, clk cycles per output sample; must be > NUM_CH+2 (elaboration assertion).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_ch  in  clog2(NUM_CH) max 1  target channel
- cfg_addr  in  2  field: 0 step, 1 duty, 2 mode, 3 volume
- cfg_data  in  ACC_W  write data; low bits used for narrow fields
- amplitude  out  OUT_W  mixed sample, registered
- sample_strobe  out  1  one-cycle pulse when amplitude updates

Behaviour:
- Reset state: all per-channel step/duty/mode/volume/phase = 0, amplitude = 0, sample_strobe = 0, cfg_ready = 1, FSM = IDLE, divider = 0.
- Divider: counts 0..SAMPLE_DIV-1 and wraps. A tick fires when it wraps to 0.
- FSM IDLE: cfg_ready = 1. On tick, go to ACCUM and clear the channel index and the sum.
- FSM ACCUM: one channel per cycle, idx 0..NUM_CH-1. For each channel:
  - phase += step, modulo 2^ACC_W. Phase is held when mode = off.
  - Compute the wave value from the pre-increment phase.
  - Add scaled = (wave*(volume+1))>>8 to the sum.
  - After idx NUM_CH-1, go to OUTPUT.
- FSM OUTPUT: latch amplitude, assert sample_strobe for exactly this cycle, return to IDLE.
- Latency: amplitude is valid NUM_CH+1 cycles after the tick cycle.
- cfg_ready = 0 in ACCUM and OUTPUT. Writes are never dropped silently; they stall.
- A write accepted in the tick cycle is visible to this sample.
- Field widths:
  - step: ACC_W bits.
  - duty: 16 bits.
  - mode: 2 bits (0 off, 1 pulse, 2 saw, 3 tri).
  - volume: 8 bits.
- Writing the mode field also clears that channel's phase to 0.
- Wave shaping, with P = phase[ACC_W-1 -: 16]:
  - off: wave = 0.
  - pulse: wave = (P < duty) ? all-ones : 0. duty = 0 gives always 0; duty = 0xFFFF gives high 65535/65536.
  - saw: wave = phase[ACC_W-1 -: OUT_W].
  - tri: t = phase[ACC_W-2 -: OUT_W]; wave = phase[ACC_W-1] ? ~t : t.
- Mix: sum width is OUT_W + clog2(NUM_CH). Default output = sum >> clog2(NUM_CH), i.e. the average, so it cannot overflow.
- Reset mid-ACCUM/OUTPUT: abort immediately to the reset state; no strobe is emitted.
- Out-of-range cfg_ch when NUM_CH is not a full power of 2 cannot occur, because NUM_CH is restricted to powers of 2.

Optional Feature:
- Macro: MIX_SATURATE_EN.
- Defined: amplitude = min(sum, 2^OUT_W-1), i.e. a saturating sum, no averaging. Gives louder single channels.
- Undefined: averaging as above.
- Every other behaviour, including latency, is identical in both builds.

Decomposition:
- Package mwg_pkg:
  - mode enum: MODE_OFF, MODE_PULSE, MODE_SAW, MODE_TRI.
  - cfg_addr constants: CFG_STEP, CFG_DUTY, CFG_MODE, CFG_VOL.
  - FSM state enum: IDLE, ACCUM, OUTPUT.
- Sub-module wave_shape: combinational. Inputs are mode, phase, duty and volume; output is the scaled OUT_W-bit value. It is instantiated once and shared across channels.

Test Plan:
All scenarios use NUM_CH=4, ACC_W=32, OUT_W=8, SAMPLE_DIV=16.
- Reset: hold rst 3 cycles then release -> amplitude 0, sample_strobe 0, cfg_ready 1; first strobe 16+5 cycles after release, amplitude 0.
- Saw: ch0 step 0x1000_0000, vol 255, mode saw; other channels off -> successive amplitudes 0,4,8,...,60 then wrap to 0 (wave 0x00,0x10,... averaged /4).
- Pulse: ch1 step 0x2000_0000, duty 0x8000, vol 255 -> amplitude pattern 63,63,63,63,0,0,0,0 repeating; a duty write of 0 gives constant 0.
- Stall: assert cfg_valid during ACCUM -> cfg_ready 0, no field change until IDLE; write then accepted; the strobe still arrives exactly every 16 cycles.
- Mix: ch0 and ch1 as pulse, duty 0xFFFF, vol 199 (wave 255 scaled to 199) -> default build amplitude 99; with MIX_SATURATE_EN, amplitude 255 (sum 398 clipped).
- Reset mid-ACCUM: assert rst on the 2nd ACCUM cycle -> no strobe that period, amplitude 0, all phases 0, config cleared.
